// File: rtl/user_input_irq.sv
// user_input_irq: Avalon-MM slave that synchronises and debounces the board
// keys and switches and captures qualifying edges. It raises a level
// interrupt to the HPS whenever an enabled captured edge is pending.
module user_input_irq #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int NUM_KEYS        = 4,
   parameter int NUM_SWITCHES    = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [NUM_KEYS-1:0]     keys,
   input  logic [NUM_SWITCHES-1:0] switches,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam int NUM_IN = NUM_KEYS + NUM_SWITCHES;
   localparam int CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_IN-1:0]         w_in;
   logic [NUM_IN-1:0]         r_sync1;
   logic [NUM_IN-1:0]         r_sync2;
   logic [NUM_IN-1:0]         r_db;
   logic [NUM_IN-1:0][CW-1:0] r_cnt;
   logic [NUM_IN-1:0]         w_dbNext;
   logic [NUM_IN-1:0][CW-1:0] w_cntNext;
   logic [NUM_IN-1:0]         w_rise;
   logic [NUM_IN-1:0]         w_fall;
   logic [NUM_IN-1:0]         w_clr;
   logic [NUM_IN-1:0]         w_edgeNext;
   logic [NUM_IN-1:0]         r_mask;
   logic [NUM_IN-1:0]         r_edge;
   logic [NUM_IN-1:0]         r_edgeSel;
   logic [31:0]               w_rdMux;
   logic                      w_wrMask;
   logic                      w_wrEdge;
   logic                      w_wrEdgeSel;
   logic                      w_unused;

   // Keys are active-low on the board, so invert them to make pressed = 1.
   assign w_in = {switches, ~keys};

   // Upper write-data bits have no register behind them.
   assign w_unused = ^writedata[31:NUM_IN];

   assign w_wrMask    = write && (address == 2'd1);
   assign w_wrEdge    = write && (address == 2'd2);
   assign w_wrEdgeSel = write && (address == 2'd3);

   // Two-flop synchroniser for every asynchronous board input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_in;
         r_sync2 <= r_sync1;
      end
   end

   // Per-bit debounce: count consecutive clocks the synchronised level differs
   // from the accepted level and accept it once the window has elapsed.
   always_comb begin
      w_dbNext  = r_db;
      w_cntNext = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (r_sync2[i] != r_db[i]) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_dbNext[i] = r_sync2[i];
            end else begin
               w_cntNext[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Debounced level and counters; reset discards any partial count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_db  <= '0;
         r_cnt <= '0;
      end else begin
         r_db  <= w_dbNext;
         r_cnt <= w_cntNext;
      end
   end

   // Edge capture: a new set wins over a same-cycle write-one-to-clear.
   always_comb begin
      w_rise     = w_dbNext & ~r_db;
      w_fall     = ~w_dbNext & r_db;
      w_clr      = w_wrEdge ? writedata[NUM_IN-1:0] : '0;
      w_edgeNext = (r_edge & ~w_clr) | w_rise | (w_fall & r_edgeSel);
   end

   // Software-visible control and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask    <= '0;
         r_edge    <= '0;
         r_edgeSel <= '0;
      end else begin
         r_edge <= w_edgeNext;
         if (w_wrMask) begin
            r_mask <= writedata[NUM_IN-1:0];
         end
         if (w_wrEdgeSel) begin
            r_edgeSel <= writedata[NUM_IN-1:0];
         end
      end
   end

   // Read mux uses current register values, so a simultaneous write is not
   // visible until the following read.
   always_comb begin
      w_rdMux = '0;
      case (address)
         2'd0:    w_rdMux = 32'(r_db);
         2'd1:    w_rdMux = 32'(r_mask);
         2'd2:    w_rdMux = 32'(r_edge);
         default: w_rdMux = 32'(r_edgeSel);
      endcase
   end

   // Registered read data (latency 1, held between reads) and level interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         if (read) begin
            readdata <= w_rdMux;
         end
         irq <= |(r_edge & r_mask);
      end
   end

endmodule

// File: tb/tb_user_input_irq.sv
// tb_user_input_irq: directed stimulus for user_input_irq with a read-data
// scoreboard. Expected values are hand-computed for DEBOUNCE_CYCLES = 4.
module tb_user_input_irq;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] data;
   } ExpRead;

   logic        clk;
   logic        reset_n;
   logic [3:0]  keys;
   logic [4:0]  switches;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   ExpRead expQ[$];
   int     vectorCount;
   int     missCount;

   user_input_irq #(
      .DEBOUNCE_CYCLES(4),
      .NUM_KEYS(4),
      .NUM_SWITCHES(5)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .keys(keys),
      .switches(switches),
      .address(address),
      .read(read),
      .write(write),
      .writedata(writedata),
      .readdata(readdata),
      .irq(irq)
   );

   // Free-running 100 MHz bench clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: whenever a read is sampled, compare the returned word against
   // the oldest expected entry once the registered data has settled.
   initial begin
      ExpRead e;
      forever begin
         @(posedge clk);
         if (read) begin
            #1;
            vectorCount++;
            if (expQ.size() == 0) begin
               missCount++;
               $display("[TB] FAIL read-unexpected: got 0x%h with no expected entry", readdata);
            end else begin
               e = expQ.pop_front();
               if (readdata !== e.data) begin
                  missCount++;
                  $display("[TB] FAIL read-addr%0d: got 0x%h expected 0x%h", e.addr, readdata, e.data);
               end
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      ExpRead e;
      e.addr  = addr;
      e.data  = data;
      expQ.push_back(e);
      address = addr;
      read    = 1'b1;
      tick(1);
      read    = 1'b0;
   endtask

   task automatic doWrite(input logic [1:0] addr, input logic [31:0] data);
      address   = addr;
      writedata = data;
      write     = 1'b1;
      tick(1);
      write     = 1'b0;
      writedata = '0;
   endtask

   task automatic checkOutput(input string name, input logic expIrq);
      vectorCount++;
      if (irq !== expIrq) begin
         missCount++;
         $display("[TB] FAIL %s: got irq=%b expected irq=%b", name, irq, expIrq);
      end
   endtask

   // Directed test sequence.
   initial begin
      vectorCount = 0;
      missCount   = 0;
      reset_n     = 1'b0;
      keys        = 4'hF;
      switches    = 5'h00;
      address     = 2'd0;
      read        = 1'b0;
      write       = 1'b0;
      writedata   = '0;
      tick(3);
      reset_n = 1'b1;
      tick(2);

      // Reset state with idle inputs.
      checkOutput("reset-irq", 1'b0);
      for (int a = 0; a < 4; a++) applyStimulus(2'(a), 32'h0);

      // Short bounce on keys[0] must be rejected.
      keys[0] = 1'b0;
      tick(3);
      keys[0] = 1'b1;
      tick(8);
      applyStimulus(2'd0, 32'h000);
      applyStimulus(2'd2, 32'h000);

      // Held press: DATA still 0 after 5 clocks, 1 after the 6th.
      keys[0] = 1'b0;
      tick(5);
      applyStimulus(2'd0, 32'h000);
      applyStimulus(2'd0, 32'h001);
      applyStimulus(2'd2, 32'h001);

      // Enable interrupt and clear it.
      doWrite(2'd1, 32'h001);
      checkOutput("irq-before-mask-effect", 1'b0);
      tick(1);
      checkOutput("irq-after-mask", 1'b1);
      doWrite(2'd2, 32'h001);
      checkOutput("irq-same-clock-as-clear", 1'b1);
      tick(1);
      checkOutput("irq-after-clear", 1'b0);
      applyStimulus(2'd2, 32'h000);

      // Release keys[0]: falling edge ignored with EDGE_SEL = 0.
      keys[0] = 1'b1;
      tick(8);
      applyStimulus(2'd2, 32'h000);
      checkOutput("irq-release", 1'b0);

      // Switch 0 on then off, rising edge only.
      switches[0] = 1'b1;
      tick(8);
      applyStimulus(2'd2, 32'h010);
      switches[0] = 1'b0;
      tick(8);
      applyStimulus(2'd0, 32'h000);
      applyStimulus(2'd2, 32'h010);
      checkOutput("irq-unmasked-edge", 1'b0);
      doWrite(2'd2, 32'h010);

      // Both edges captured with EDGE_SEL[4] = 1.
      doWrite(2'd3, 32'h010);
      applyStimulus(2'd2, 32'h000);
      applyStimulus(2'd3, 32'h010);
      switches[0] = 1'b1;
      tick(8);
      applyStimulus(2'd2, 32'h010);
      doWrite(2'd2, 32'h010);
      applyStimulus(2'd2, 32'h000);
      switches[0] = 1'b0;
      tick(8);
      applyStimulus(2'd2, 32'h010);
      doWrite(2'd2, 32'h010);

      // Collision: clear of EDGE[1] on the clock its debounce completes.
      doWrite(2'd1, 32'h002);
      keys[1] = 1'b0;
      tick(5);
      doWrite(2'd2, 32'h002);
      tick(1);
      checkOutput("irq-collision", 1'b1);
      tick(3);
      checkOutput("irq-collision-hold", 1'b1);
      applyStimulus(2'd2, 32'h002);

      // Fill EDGE with every input, then reset mid-debounce.
      doWrite(2'd3, 32'h1FF);
      keys     = 4'h0;
      switches = 5'h1F;
      tick(8);
      applyStimulus(2'd2, 32'h1FF);
      applyStimulus(2'd0, 32'h1FF);
      switches[0] = 1'b0;
      tick(4);
      reset_n = 1'b0;
      tick(1);
      checkOutput("irq-in-reset", 1'b0);
      tick(1);
      reset_n = 1'b1;

      // After release: registers are clear and the held inputs need the full window.
      for (int a = 0; a < 4; a++) applyStimulus(2'(a), 32'h0);
      checkOutput("irq-after-reset", 1'b0);
      applyStimulus(2'd2, 32'h000);
      applyStimulus(2'd2, 32'h000);
      applyStimulus(2'd2, 32'h1EF);
      applyStimulus(2'd0, 32'h1EF);
      tick(2);
      checkOutput("irq-masked-after-reset", 1'b0);

      tick(2);
      if (expQ.size() != 0) begin
         missCount++;
         $display("[TB] FAIL scoreboard-drain: got %0d entries expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
